// File: rtl/ball_pkg.sv
// ball_pkg: constants and types shared by the ball sprite arbiter slice.
//   BALL_SIZE     on-screen ball width/height in pixels
//   COORD_W       pixel/position coordinate width
//   NUM_BALLS_DEF default number of ball instances
//   ball_pos_t    top-left position of one ball
//   ball_idx_t    ball identifier at the default ball count
//   arb_state_t   arbiter FSM state
package ball_pkg;

    localparam int BALL_SIZE     = 13;
    localparam int COORD_W       = 11;
    localparam int NUM_BALLS_DEF = 4;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } ball_pos_t;

    typedef logic [$clog2(NUM_BALLS_DEF)-1:0] ball_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ball_sprite_arbiter_if.sv
// ball_sprite_arbiter_if: groups the scan, register-write and bitmap-side
// signals of the ball sprite arbiter.
//   master : drives pixel scan, startOfFrame and the position/enable writes,
//            receives bitmap offsets, ball id and overlap report
//   slave  : the arbiter itself (mirror image of master)
interface ball_sprite_arbiter_if
    import ball_pkg::*;
#(
    parameter int NUM_BALLS = NUM_BALLS_DEF
);
    localparam int IDX_W = $clog2(NUM_BALLS);

    logic [COORD_W-1:0]   pixelX;
    logic [COORD_W-1:0]   pixelY;
    logic                 startOfFrame;
    logic                 pos_wr;
    logic [IDX_W-1:0]     pos_idx;
    logic [COORD_W-1:0]   pos_x;
    logic [COORD_W-1:0]   pos_y;
    logic                 en_wr;
    logic [NUM_BALLS-1:0] en_mask;
    logic [COORD_W-1:0]   offsetX;
    logic [COORD_W-1:0]   offsetY;
    logic                 InsideRectangle;
    logic [IDX_W-1:0]     ballId;
    logic                 ballIdValid;
    logic [NUM_BALLS-1:0] overlap_mask;

    modport master (
        output pixelX, pixelY, startOfFrame,
        output pos_wr, pos_idx, pos_x, pos_y, en_wr, en_mask,
        input  offsetX, offsetY, InsideRectangle, ballId, ballIdValid, overlap_mask
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame,
        input  pos_wr, pos_idx, pos_x, pos_y, en_wr, en_mask,
        output offsetX, offsetY, InsideRectangle, ballId, ballIdValid, overlap_mask
    );

endinterface

// File: rtl/ball_hit_test.sv
// ball_hit_test: combinational bounds check of the scan pixel against one ball.
//   en_i       ball enabled (active register)
//   pos_i      ball top-left position
//   pixel_x_i  scan pixel X
//   pixel_y_i  scan pixel Y
//   hit_o      pixel lies inside the BALL_SIZE x BALL_SIZE box
//   off_x_o    pixel X relative to ball X (meaningful only with hit_o)
//   off_y_o    pixel Y relative to ball Y (meaningful only with hit_o)
module ball_hit_test
    import ball_pkg::*;
(
    input  logic               en_i,
    input  ball_pos_t          pos_i,
    input  logic [COORD_W-1:0] pixel_x_i,
    input  logic [COORD_W-1:0] pixel_y_i,
    output logic               hit_o,
    output logic [COORD_W-1:0] off_x_o,
    output logic [COORD_W-1:0] off_y_o
);

    // One extra bit on the far edge so a ball near the right/bottom border
    // cannot wrap around and claim pixels at the left/top of the screen.
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    assign x_end = {1'b0, pos_i.x} + (COORD_W+1)'(BALL_SIZE);
    assign y_end = {1'b0, pos_i.y} + (COORD_W+1)'(BALL_SIZE);

    assign hit_o = en_i
                 && (pixel_x_i >= pos_i.x) && ({1'b0, pixel_x_i} < x_end)
                 && (pixel_y_i >= pos_i.y) && ({1'b0, pixel_y_i} < y_end);

    assign off_x_o = pixel_x_i - pos_i.x;
    assign off_y_o = pixel_y_i - pos_i.y;

endmodule

// File: rtl/ball_sprite_arbiter.sv
// ball_sprite_arbiter: shares one ball bitmap lookup between NUM_BALLS balls.
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    slave side of ball_sprite_arbiter_if:
//          in : pixelX/Y, startOfFrame, pos_wr/pos_idx/pos_x/pos_y, en_wr/en_mask
//          out: offsetX/Y, InsideRectangle (t+1), ballId/ballIdValid (t+2),
//               overlap_mask (previous frame)
// Positions and enables are written to pending registers and copied into the
// active set on startOfFrame; the lowest-index ball covering a pixel wins.
module ball_sprite_arbiter
    import ball_pkg::*;
#(
    parameter int NUM_BALLS = NUM_BALLS_DEF
)(
    input  logic                  clk,
    input  logic                  reset,
    ball_sprite_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_BALLS);

    arb_state_t           state_q, state_d;

    ball_pos_t            pend_q [NUM_BALLS];
    ball_pos_t            pend_d [NUM_BALLS];
    ball_pos_t            act_q  [NUM_BALLS];
    logic [NUM_BALLS-1:0] pend_en_q, pend_en_d, act_en_q;

    logic [NUM_BALLS-1:0] hit_raw, hit, ovl_bits;
    logic [COORD_W-1:0]   off_x [NUM_BALLS];
    logic [COORD_W-1:0]   off_y [NUM_BALLS];
    logic [COORD_W-1:0]   sel_x, sel_y;
    logic [IDX_W-1:0]     sel_id;

    logic [NUM_BALLS-1:0] sticky_q, overlap_q;
    logic [COORD_W-1:0]   offx_q, offy_q;
    logic                 inside_q, valid2_q;
    logic [IDX_W-1:0]     id1_q, id2_q;

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_hit
        ball_hit_test u_hit (
            .en_i      (act_en_q[g]),
            .pos_i     (act_q[g]),
            .pixel_x_i (bus.pixelX),
            .pixel_y_i (bus.pixelY),
            .hit_o     (hit_raw[g]),
            .off_x_o   (off_x[g]),
            .off_y_o   (off_y[g])
        );
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaults first so no path through the block leaves a variable
        // unassigned, which would infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.startOfFrame) state_d = RUN;
            RUN:  state_d = RUN;
        endcase
    end

    // Nothing is drawn until the first frame has been committed.
    assign hit = (state_q == RUN) ? hit_raw : '0;

    // Two or more bits set: clearing the lowest set bit leaves something.
    assign ovl_bits = ((hit & (hit - NUM_BALLS'(1))) != '0) ? hit : '0;

    // Pending next-state: includes a write in the same cycle as a commit.
    always_comb begin
        pend_d    = pend_q;
        pend_en_d = pend_en_q;
        if (bus.pos_wr) pend_d[bus.pos_idx] = '{x: bus.pos_x, y: bus.pos_y};
        if (bus.en_wr)  pend_en_d = bus.en_mask;
    end

    // Priority encoder: scanning downward leaves the lowest hit index last.
    always_comb begin
        sel_x  = '0;
        sel_y  = '0;
        sel_id = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_x  = off_x[i];
                sel_y  = off_y[i];
                sel_id = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the position/enable register file is small and must read
            // as zero after reset, so it is reset like ordinary flops.
            for (int i = 0; i < NUM_BALLS; i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
            end
            pend_en_q <= '0;
            act_en_q  <= '0;
            sticky_q  <= '0;
            overlap_q <= '0;
            offx_q    <= '0;
            offy_q    <= '0;
            inside_q  <= 1'b0;
            id1_q     <= '0;
            id2_q     <= '0;
            valid2_q  <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            pend_en_q <= pend_en_d;
            if (bus.startOfFrame) begin
                act_q     <= pend_d;
                act_en_q  <= pend_en_d;
                overlap_q <= sticky_q;
                sticky_q  <= ovl_bits;   // new frame starts with this pixel only
            end else begin
                sticky_q  <= sticky_q | ovl_bits;
            end
            // Stage 1: bitmap addressing.
            inside_q <= |hit;
            offx_q   <= sel_x;
            offy_q   <= sel_y;
            id1_q    <= sel_id;
            // Stage 2: id lines up with the bitmap's registered RGB output.
            id2_q    <= id1_q;
            valid2_q <= inside_q;
        end
    end

    assign bus.offsetX         = offx_q;
    assign bus.offsetY         = offy_q;
    assign bus.InsideRectangle = inside_q;
    assign bus.ballId          = id2_q;
    assign bus.ballIdValid     = valid2_q;
    assign bus.overlap_mask    = overlap_q;

endmodule

// File: tb/tb_ball_sprite_arbiter.sv
// tb_ball_sprite_arbiter: directed scenarios plus randomized scan against a
// frame-level reference model of the ball sprite arbiter.
module tb_ball_sprite_arbiter;
    import ball_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ball_sprite_arbiter_if #(.NUM_BALLS(N)) bif ();

    ball_sprite_arbiter #(.NUM_BALLS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    // Reference model: pending/active ball tables and per-frame overlap set.
    int pend_x [N];
    int pend_y [N];
    int act_x  [N];
    int act_y  [N];
    bit pend_en[N];
    bit act_en [N];
    bit m_run;
    int m_sticky;
    int s1_id;
    bit s1_inside;

    // Expected outputs after the most recent edge.
    int e_offx, e_offy, e_id, e_ovl;
    bit e_inside, e_valid;

    int passed = 0;
    int total  = 0;

    function automatic bit covers(int i, int px, int py);
        return act_en[i] && px >= act_x[i] && px < act_x[i] + BALL_SIZE
                         && py >= act_y[i] && py < act_y[i] + BALL_SIZE;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            pend_x[i] = 0; pend_y[i] = 0; act_x[i] = 0; act_y[i] = 0;
            pend_en[i] = 0; act_en[i] = 0;
        end
        m_run = 0; m_sticky = 0; s1_id = 0; s1_inside = 0;
        e_offx = 0; e_offy = 0; e_id = 0; e_ovl = 0; e_inside = 0; e_valid = 0;
    endtask

    // Advance one clock with the inputs currently on the bus, update the
    // model, then settle 1 time unit past the edge and drop the strobes.
    task automatic cycle();
        int px, py, win, hits, nhit;
        @(posedge clk);
        px = int'(bif.pixelX);
        py = int'(bif.pixelY);
        win = -1; hits = 0; nhit = 0;
        if (m_run) begin
            for (int i = 0; i < N; i++) begin
                if (covers(i, px, py)) begin
                    hits |= (1 << i);
                    nhit++;
                    if (win < 0) win = i;
                end
            end
        end
        if (reset) begin
            model_clear();
        end else begin
            e_id    = s1_id;
            e_valid = s1_inside;
            if (win >= 0) begin
                e_inside = 1; e_offx = px - act_x[win]; e_offy = py - act_y[win];
                s1_id = win;
            end else begin
                e_inside = 0; e_offx = 0; e_offy = 0;
                s1_id = 0;
            end
            s1_inside = e_inside;
            if (bif.pos_wr) begin
                pend_x[bif.pos_idx] = int'(bif.pos_x);
                pend_y[bif.pos_idx] = int'(bif.pos_y);
            end
            if (bif.en_wr)
                for (int i = 0; i < N; i++) pend_en[i] = bif.en_mask[i];
            if (bif.startOfFrame) begin
                e_ovl    = m_sticky;
                m_sticky = (nhit >= 2) ? hits : 0;
                for (int i = 0; i < N; i++) begin
                    act_x[i] = pend_x[i]; act_y[i] = pend_y[i]; act_en[i] = pend_en[i];
                end
                m_run = 1;
            end else if (nhit >= 2) begin
                m_sticky |= hits;
            end
        end
        #1;
        bif.pos_wr = 1'b0;
        bif.en_wr = 1'b0;
        bif.startOfFrame = 1'b0;
    endtask

    task automatic set_pixel(int x, int y);
        bif.pixelX = COORD_W'(x);
        bif.pixelY = COORD_W'(y);
    endtask

    task automatic write_pos(int idx, int x, int y);
        bif.pos_wr = 1'b1;
        bif.pos_idx = 2'(idx);
        bif.pos_x = COORD_W'(x);
        bif.pos_y = COORD_W'(y);
    endtask

    task automatic write_en(logic [N-1:0] m);
        bif.en_wr = 1'b1;
        bif.en_mask = m;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        total += 6;
        if (bif.offsetX !== '0) $display("FAIL reset_offx: got %0d want 0", bif.offsetX); else passed++;
        if (bif.offsetY !== '0) $display("FAIL reset_offy: got %0d want 0", bif.offsetY); else passed++;
        if (bif.InsideRectangle !== 1'b0) $display("FAIL reset_inside: got %b want 0", bif.InsideRectangle); else passed++;
        if (bif.ballId !== '0) $display("FAIL reset_id: got %0d want 0", bif.ballId); else passed++;
        if (bif.ballIdValid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bif.ballIdValid); else passed++;
        if (bif.overlap_mask !== '0) $display("FAIL reset_ovl: got %b want 0", bif.overlap_mask); else passed++;
    endtask

    task automatic test_idle_no_commit();
        write_pos(0, 100, 50); cycle();
        write_en(4'b0001); cycle();
        set_pixel(106, 56);
        for (int k = 0; k < 3; k++) begin
            cycle();
            total += 2;
            if (bif.InsideRectangle !== 1'b0) $display("FAIL idle_inside: got %b want 0", bif.InsideRectangle); else passed++;
            if (bif.ballIdValid !== 1'b0) $display("FAIL idle_valid: got %b want 0", bif.ballIdValid); else passed++;
        end
    endtask

    task automatic test_basic_hit();
        set_pixel(0, 0);
        bif.startOfFrame = 1'b1; cycle();
        set_pixel(106, 56); cycle();
        total += 3;
        if (bif.offsetX !== 11'd6) $display("FAIL basic_offx: got %0d want 6", bif.offsetX); else passed++;
        if (bif.offsetY !== 11'd6) $display("FAIL basic_offy: got %0d want 6", bif.offsetY); else passed++;
        if (bif.InsideRectangle !== 1'b1) $display("FAIL basic_inside: got %b want 1", bif.InsideRectangle); else passed++;
        set_pixel(0, 0); cycle();
        total += 3;
        if (bif.ballId !== 2'd0) $display("FAIL basic_id: got %0d want 0", bif.ballId); else passed++;
        if (bif.ballIdValid !== 1'b1) $display("FAIL basic_valid: got %b want 1", bif.ballIdValid); else passed++;
        if (bif.InsideRectangle !== 1'b0) $display("FAIL basic_miss_inside: got %b want 0", bif.InsideRectangle); else passed++;
    endtask

    task automatic test_priority_overlap();
        write_pos(2, 105, 50); cycle();
        write_en(4'b0101); cycle();
        bif.startOfFrame = 1'b1; cycle();
        set_pixel(107, 52); cycle();
        total += 2;
        if (bif.offsetX !== 11'd7) $display("FAIL prio_offx: got %0d want 7", bif.offsetX); else passed++;
        if (bif.InsideRectangle !== 1'b1) $display("FAIL prio_inside: got %b want 1", bif.InsideRectangle); else passed++;
        set_pixel(0, 0); cycle();
        total += 2;
        if (bif.ballId !== 2'd0) $display("FAIL prio_id: got %0d want 0", bif.ballId); else passed++;
        if (bif.ballIdValid !== 1'b1) $display("FAIL prio_valid: got %b want 1", bif.ballIdValid); else passed++;
        bif.startOfFrame = 1'b1; cycle();
        total++;
        if (bif.overlap_mask !== 4'b0101) $display("FAIL prio_overlap: got %b want 0101", bif.overlap_mask); else passed++;
    endtask

    task automatic test_right_edge();
        write_pos(1, 2040, 0); cycle();
        write_en(4'b0010); cycle();
        bif.startOfFrame = 1'b1; cycle();
        set_pixel(2047, 5); cycle();
        total += 3;
        if (bif.offsetX !== 11'd7) $display("FAIL edge_offx: got %0d want 7", bif.offsetX); else passed++;
        if (bif.offsetY !== 11'd5) $display("FAIL edge_offy: got %0d want 5", bif.offsetY); else passed++;
        if (bif.InsideRectangle !== 1'b1) $display("FAIL edge_inside: got %b want 1", bif.InsideRectangle); else passed++;
        set_pixel(0, 5); cycle();
        total += 3;
        if (bif.InsideRectangle !== 1'b0) $display("FAIL edge_nowrap: got %b want 0", bif.InsideRectangle); else passed++;
        if (bif.ballId !== 2'd1) $display("FAIL edge_id: got %0d want 1", bif.ballId); else passed++;
        if (bif.ballIdValid !== 1'b1) $display("FAIL edge_valid: got %b want 1", bif.ballIdValid); else passed++;
    endtask

    task automatic test_same_cycle_commit();
        set_pixel(0, 0);
        write_pos(0, 200, 200);
        write_en(4'b0001);
        bif.startOfFrame = 1'b1; cycle();
        set_pixel(200, 200); cycle();
        total += 3;
        if (bif.InsideRectangle !== 1'b1) $display("FAIL samecyc_inside: got %b want 1", bif.InsideRectangle); else passed++;
        if (bif.offsetX !== 11'd0) $display("FAIL samecyc_offx: got %0d want 0", bif.offsetX); else passed++;
        if (bif.offsetY !== 11'd0) $display("FAIL samecyc_offy: got %0d want 0", bif.offsetY); else passed++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 7) == 0)
                    write_pos($urandom_range(0, N-1), $urandom_range(2030, 2047), $urandom_range(2030, 2047));
                else
                    write_pos($urandom_range(0, N-1), $urandom_range(90, 130), $urandom_range(40, 70));
            end
            if ($urandom_range(0, 7) == 0) write_en(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 15) == 0) bif.startOfFrame = 1'b1;
            case ($urandom_range(0, 7))
                0:       set_pixel($urandom_range(0, 2047), $urandom_range(0, 2047));
                1:       set_pixel($urandom_range(2028, 2047), $urandom_range(2028, 2047));
                2:       set_pixel($urandom_range(0, 12), $urandom_range(0, 12));
                default: set_pixel($urandom_range(85, 150), $urandom_range(35, 90));
            endcase
            cycle();
            total += 6;
            if (bif.offsetX !== COORD_W'(e_offx)) $display("FAIL rnd_offx: got %0d want %0d", bif.offsetX, e_offx); else passed++;
            if (bif.offsetY !== COORD_W'(e_offy)) $display("FAIL rnd_offy: got %0d want %0d", bif.offsetY, e_offy); else passed++;
            if (bif.InsideRectangle !== e_inside) $display("FAIL rnd_inside: got %b want %b", bif.InsideRectangle, e_inside); else passed++;
            if (bif.ballId !== 2'(e_id)) $display("FAIL rnd_id: got %0d want %0d", bif.ballId, e_id); else passed++;
            if (bif.ballIdValid !== e_valid) $display("FAIL rnd_valid: got %b want %b", bif.ballIdValid, e_valid); else passed++;
            if (bif.overlap_mask !== 4'(e_ovl)) $display("FAIL rnd_ovl: got %b want %b", bif.overlap_mask, 4'(e_ovl)); else passed++;
        end
    endtask

    task automatic test_reset_mid_frame();
        // Force a known overlapping frame so overlap_mask is non-zero first.
        write_pos(0, 300, 300); cycle();
        write_pos(3, 305, 305); cycle();
        write_en(4'b1001); cycle();
        bif.startOfFrame = 1'b1; cycle();
        set_pixel(306, 306); cycle();
        bif.startOfFrame = 1'b1; cycle();
        total += 2;
        if (bif.overlap_mask !== 4'b1001) $display("FAIL mid_pre_ovl: got %b want 1001", bif.overlap_mask); else passed++;
        if (bif.InsideRectangle !== 1'b1) $display("FAIL mid_pre_inside: got %b want 1", bif.InsideRectangle); else passed++;
        reset = 1'b1; cycle();
        reset = 1'b0;
        total += 6;
        if (bif.offsetX !== '0) $display("FAIL mid_offx: got %0d want 0", bif.offsetX); else passed++;
        if (bif.offsetY !== '0) $display("FAIL mid_offy: got %0d want 0", bif.offsetY); else passed++;
        if (bif.InsideRectangle !== 1'b0) $display("FAIL mid_inside: got %b want 0", bif.InsideRectangle); else passed++;
        if (bif.ballId !== '0) $display("FAIL mid_id: got %0d want 0", bif.ballId); else passed++;
        if (bif.ballIdValid !== 1'b0) $display("FAIL mid_valid: got %b want 0", bif.ballIdValid); else passed++;
        if (bif.overlap_mask !== '0) $display("FAIL mid_ovl: got %b want 0", bif.overlap_mask); else passed++;
        // Back in IDLE with empty tables: the same pixel must stay dark.
        for (int k = 0; k < 2; k++) begin
            cycle();
            total += 2;
            if (bif.InsideRectangle !== 1'b0) $display("FAIL mid_idle_inside: got %b want 0", bif.InsideRectangle); else passed++;
            if (bif.ballIdValid !== 1'b0) $display("FAIL mid_idle_valid: got %b want 0", bif.ballIdValid); else passed++;
        end
    endtask

    initial begin
        reset = 1'b1;
        bif.pixelX = '0;
        bif.pixelY = '0;
        bif.startOfFrame = 1'b0;
        bif.pos_wr = 1'b0;
        bif.pos_idx = '0;
        bif.pos_x = '0;
        bif.pos_y = '0;
        bif.en_wr = 1'b0;
        bif.en_mask = '0;
        model_clear();

        test_reset();
        test_idle_no_commit();
        test_basic_hit();
        test_priority_overlap();
        test_right_edge();
        test_same_cycle_commit();
        test_random();
        test_reset_mid_frame();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
